// File: rtl/cat_cmd_tx.sv
// cat_cmd_tx: encodes cat hit/revive/clear requests into ASCII command bytes,
// queues them in a small FIFO and sends each one as an 8N1 UART frame on tx.
module cat_cmd_tx #(
    parameter int CLK_FREQ = 103_340_000,
    parameter int BAUD     = 115200,
    parameter int QDEPTH   = 4            // power of two, >= 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_kind,
    input  logic [2:0] cmd_idx,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic       cmd_err
);

    // Bit period in clock cycles; must be at least 2.
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int TW  = $clog2(DIV);
    localparam int PW  = $clog2(QDEPTH);

    localparam logic [TW-1:0] BIT_LAST = TW'(DIV - 1);
    localparam logic [TW-1:0] DONE_AT  = TW'(DIV - 2);

    localparam logic [1:0] KIND_HIT     = 2'b00;
    localparam logic [1:0] KIND_REVIVE  = 2'b01;
    localparam logic [1:0] KIND_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic          tx_q, tx_d;
    logic          frame_done_q, frame_done_d;
    logic          cmd_err_q, cmd_err_d;
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    fifo_mem_q [QDEPTH];

    logic          fifo_empty;
    logic          fifo_full;
    logic          accept;
    logic          push;
    logic          pop;
    logic          bit_end;
    logic [7:0]    push_byte;
    logic [7:0]    head_byte;

    // ASCII command byte for a legal request: 'A'+idx, 'a'+idx, or '`'.
    function automatic logic [7:0] encode_cmd(input logic [1:0] kind, input logic [2:0] idx);
        logic [7:0] b;
        case (kind)
            KIND_HIT:    b = 8'h41 + {5'd0, idx};
            KIND_REVIVE: b = 8'h61 + {5'd0, idx};
            default:     b = 8'h60;
        endcase
        return b;
    endfunction

    // FIFO status and request handshake; an illegal kind is consumed but never stored.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        accept     = cmd_valid & ~fifo_full;
        push       = accept & (cmd_kind != KIND_ILLEGAL);
        push_byte  = encode_cmd(cmd_kind, cmd_idx);
        head_byte  = fifo_mem_q[rd_ptr_q[PW-1:0]];
        cmd_err_d  = accept & (cmd_kind == KIND_ILLEGAL);
        wr_ptr_d   = wr_ptr_q + {{PW{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{PW{1'b0}}, pop};
    end

    // Frame sequencer: next state, bit timing and the registered line value.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bitcnt_d     = bitcnt_q;
        tx_d         = tx_q;
        shift_d      = shift_q;
        frame_done_d = 1'b0;
        pop          = 1'b0;
        bit_end      = (timer_q == BIT_LAST);
        case (state_q)
            IDLE: begin
                tx_d     = 1'b1;
                timer_d  = '0;
                bitcnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head_byte;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_d  = '0;
                    bitcnt_d = '0;
                    state_d  = DATA;
                    tx_d     = shift_q[0];
                    shift_d  = {1'b0, shift_q[7:1]};
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (bitcnt_q == 3'd7) begin
                        bitcnt_d = '0;
                        state_d  = STOP;
                        tx_d     = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        tx_d     = shift_q[0];
                        shift_d  = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                // Registered pulse lands on the last cycle of the stop bit.
                frame_done_d = (timer_q == DONE_AT);
                if (bit_end) begin
                    timer_d = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit, no idle gap.
                        pop     = 1'b1;
                        shift_d = head_byte;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                timer_d = '0;
            end
        endcase
    end

    // Control state with asynchronous reset; the line idles high out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            bitcnt_q     <= '0;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
            cmd_err_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bitcnt_q     <= bitcnt_d;
            tx_q         <= tx_d;
            frame_done_q <= frame_done_d;
            cmd_err_q    <= cmd_err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Byte storage and shifter carry no reset; validity comes from the pointers and FSM.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (push) begin
            fifo_mem_q[wr_ptr_q[PW-1:0]] <= push_byte;
        end
    end

    assign tx         = tx_q;
    assign frame_done = frame_done_q;
    assign cmd_err    = cmd_err_q;
    assign cmd_ready  = ~fifo_full;
    assign busy       = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: doc/cat_cmd_tx.md
Name: cat_cmd_tx

Overview:
- Sending end of the badge cat-command UART link: encodes cat hit/revive/clear requests into ASCII command bytes and serialises them as 8N1 UART on `tx`.
- Byte set it emits:
  - 'A'..'H' (0x41..0x48): cat index 0..7 down.
  - 'a'..'h' (0x61..0x68): cat index 0..7 restored.
  - '`' (0x60): restore all.
- Sits on the controller side of the interconnect, feeding a receiving badge's UART rx. Includes a small command FIFO so button/game logic can issue bursts without waiting on the line.

Parameters:
- CLK_FREQ, 103_340_000, system clock frequency in Hz.
- BAUD, 115200, line rate; bit period DIV = CLK_FREQ/BAUD, integer truncated (default 897 cycles). DIV must be >= 2.
- QDEPTH, 4, command FIFO depth in entries, power of two.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears FIFO, FSM and counters.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  = FIFO not full; a command is accepted on a rising edge with cmd_valid & cmd_ready.
- cmd_kind  input  2  00 = hit, 01 = revive, 10 = clear all, 11 = illegal.
- cmd_idx  input  3  cat index 0..7; ignored for clear all.
- tx  output  1  UART line, idle high.
- busy  output  1  high when FIFO non-empty or a frame is in progress.
- frame_done  output  1  one-cycle pulse on the last cycle of each stop bit.
- cmd_err  output  1  one-cycle pulse the cycle after an illegal command is accepted.

Behaviour:
- Reset values:
  - tx = 1, cmd_ready = 1, busy = 0, frame_done = 0, cmd_err = 0.
  - FSM = IDLE, FIFO empty, bit timer = 0, bit count = 0.
  - Async reset mid-frame forces tx high immediately and discards the frame and all queued commands.
- Encoding at FIFO write (FIFO stores 8-bit bytes):
  - hit → 0x41 + idx.
  - revive → 0x61 + idx.
  - clear all → 0x60.
  - illegal (11): handshake completes (consumes the request), nothing is written, cmd_err pulses.
- Every output (tx, frame_done, cmd_err) is registered; tx carries no combinational path from inputs.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: tx = 1. If FIFO non-empty: pop head into shift register, go START, tx <= 0.
  - START: tx = 0 for DIV cycles, then DATA with tx <= shift[0].
  - DATA: 8 bits LSB first, each held DIV cycles, shift right after each bit. After bit 7, go STOP with tx <= 1.
  - STOP: tx = 1 for DIV cycles. frame_done = 1 on its final cycle. Then:
    - FIFO non-empty: pop, go START directly (no idle gap; next start bit begins the following cycle).
    - otherwise go IDLE.
- Latency: for a command accepted at edge E into an empty FIFO while IDLE, tx falls after edge E+1. Frame length is exactly 10·DIV cycles.
- Bit timer: counts 0..DIV-1 and wraps at a bit boundary. Bit count is 0..7 in DATA.
- FIFO:
  - Pointer wrap modulo QDEPTH; full/empty from an extra pointer bit.
  - Push and pop in the same cycle are both honoured when not full.
  - When full, cmd_ready = 0; a request is held off (not dropped) until a pop frees space. The push then lands the cycle after the pop.
  - FIFO capacity is QDEPTH entries plus the one byte in flight in the shifter.
- busy = (state != IDLE) | ~empty. busy drops the cycle after the final STOP ends with an empty FIFO.
- Back-to-back illegal + legal commands: each is handled independently; cmd_err does not block the FIFO.

Test Plan:
All scenarios use CLK_FREQ=1_000_000, BAUD=100_000 (DIV=10), QDEPTH=4.
1. Reset, hold 50 cycles idle → tx=1, busy=0, cmd_ready=1. Assert reset mid-frame (cycle 35 of a frame) → tx=1 the same cycle, busy=0, nothing further sent.
2. Single hit idx=2 → tx low one edge after accept. Line carries 0,1,1,0,0,0,0,1,0,1 (0x43 'C'), 10 cycles per bit. frame_done pulses once at cycle 100 of the frame.
3. Revive idx=7 then clear all, back-to-back → frames 0x68 then 0x60. Second start bit immediately follows the first stop bit; total 200 cycles, busy high throughout.
4. Six hits idx 0..5 with cmd_valid held high → first is popped; cmd_ready deasserts after 5 accepted (4 queued + 1 in flight). Sixth is accepted the cycle after the first STOP→START pop. Output is 'A'..'F' in order, no loss or duplication.
5. Illegal kind 11 followed by hit idx=0 → cmd_err pulses once. Only 0x41 is transmitted; the FIFO never holds a byte for the illegal command.
6. Push on the same edge the FIFO pops while 3 entries are queued → count stays 3 and the order is preserved; check the FIFO pointers across their wrap.
